// File: rtl/param_memory_pkg.sv
// Shared types and constants for the burst-mode main-memory model.
package param_memory_pkg;

    localparam int BEAT_W           = 64;
    localparam int LINE_OFFSET_BITS = 5;
    localparam int DEFAULT_BURSTS   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_e;

    // Beat k of a line lives at line[k]; sized for the default burst count.
    typedef logic [DEFAULT_BURSTS-1:0][BEAT_W-1:0] line_t;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/param_memory_if.sv
// Cache-line adaptor <-> main-memory burst bus.
interface param_memory_if;
    import param_memory_pkg::*;

    logic              read;
    logic              write;
    logic [31:0]       address;
    logic [BEAT_W-1:0] burst_i;
    logic [BEAT_W-1:0] burst_o;
    logic              resp;

    modport master (
        output read, write, address, burst_i,
        input  burst_o, resp
    );

    modport slave (
        input  read, write, address, burst_i,
        output burst_o, resp
    );

endinterface

// File: rtl/param_memory_array.sv
// Line storage held as BURSTS beats per line; simple dual-port with registered read.
module param_memory_array
    import param_memory_pkg::*;
#(
    parameter int BURSTS    = 4,
    parameter int MEM_LINES = 512
) (
    input  logic                         clk,
    input  logic [idx_w(MEM_LINES)-1:0]  line_i,
    input  logic [idx_w(BURSTS)-1:0]     rd_beat_i,
    input  logic [idx_w(BURSTS)-1:0]     wr_beat_i,
    input  logic                         we_i,
    input  logic [BEAT_W-1:0]            wdata_i,
    output logic [BEAT_W-1:0]            rdata_o
);

    localparam int DEPTH  = MEM_LINES * BURSTS;
    localparam int ADDR_W = idx_w(DEPTH);

    logic [BEAT_W-1:0] mem_q [DEPTH];
    logic [BEAT_W-1:0] rdata_q;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] wr_addr;

    assign rd_addr = ADDR_W'(int'(line_i) * BURSTS + int'(rd_beat_i));
    assign wr_addr = ADDR_W'(int'(line_i) * BURSTS + int'(wr_beat_i));

    // No reset on the storage or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[wr_addr] <= wdata_i;
        end
        rdata_q <= mem_q[rd_addr];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/param_memory.sv
// Burst-mode main-memory model: latency countdown, beat sequencing, open-page tracking.
// Open-page latency shortcut is enabled by defining PARAM_MEMORY_PAGE_HIT_EN.
module param_memory
    import param_memory_pkg::*;
#(
    parameter int DELAY      = 50,
    parameter int PAGE_DELAY = 25,
    parameter int BURSTS     = 4,
    parameter int PAGE_BYTES = 256,
    parameter int MEM_LINES  = 512
) (
    input  logic          clk,
    input  logic          rst,
    param_memory_if.slave bus
);

    localparam int LINE_W    = idx_w(MEM_LINES);
    localparam int BEAT_IW   = idx_w(BURSTS);
    localparam int MAX_DELAY = (DELAY > PAGE_DELAY) ? DELAY : PAGE_DELAY;
    localparam int CNT_W     = idx_w(MAX_DELAY);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_IW-1:0]  beat_q, beat_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                op_rd_q, op_rd_d;
    logic                resp_q, resp_d;
    logic                rd_valid_q, rd_valid_d;

    logic                accept;
    logic                req_held;
    logic                page_hit;
    logic                mem_we;
    logic [BEAT_W-1:0]   mem_rdata;
    logic                unused_addr_bits;

    assign accept   = (state_q == IDLE) && (bus.read || bus.write);
    assign req_held = op_rd_q ? bus.read : bus.write;
    assign unused_addr_bits = ^bus.address;

`ifdef PARAM_MEMORY_PAGE_HIT_EN
    localparam int PAGE_SHIFT = idx_w(PAGE_BYTES);

    logic [31-PAGE_SHIFT:0] page_q, page_d;
    logic                   page_valid_q, page_valid_d;

    assign page_hit = page_valid_q && (bus.address[31:PAGE_SHIFT] == page_q);

    always_comb begin
        page_d       = page_q;
        page_valid_d = page_valid_q;
        if (accept) begin
            page_d       = bus.address[31:PAGE_SHIFT];
            page_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            page_q       <= '0;
            page_valid_q <= 1'b0;
        end else begin
            page_q       <= page_d;
            page_valid_q <= page_valid_d;
        end
    end
`else
    logic unused_page_cfg;

    assign page_hit        = 1'b0;
    assign unused_page_cfg = (PAGE_BYTES > 0);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        line_d  = line_q;
        op_rd_d = op_rd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    line_d  = bus.address[LINE_OFFSET_BITS +: LINE_W];
                    op_rd_d = bus.read;
                    cnt_d   = page_hit ? CNT_W'(PAGE_DELAY - 1) : CNT_W'(DELAY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (!req_held) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = BURST;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BURST: begin
                if (!req_held || (beat_q == BEAT_IW'(BURSTS - 1))) begin
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered off the next state so beat 0 lands exactly L cycles after acceptance.
    always_comb begin
        resp_d     = (state_d == BURST);
        rd_valid_d = (state_d == BURST) && op_rd_d;
    end

    assign mem_we = (state_q == BURST) && !op_rd_q && bus.write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            beat_q     <= '0;
            line_q     <= '0;
            op_rd_q    <= 1'b0;
            resp_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            op_rd_q    <= op_rd_d;
            resp_q     <= resp_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Read beat for the coming cycle is fetched using next-state indices.
    param_memory_array #(
        .BURSTS    (BURSTS),
        .MEM_LINES (MEM_LINES)
    ) u_array (
        .clk       (clk),
        .line_i    (line_d),
        .rd_beat_i (beat_d),
        .wr_beat_i (beat_q),
        .we_i      (mem_we),
        .wdata_i   (bus.burst_i),
        .rdata_o   (mem_rdata)
    );

    assign bus.resp    = resp_q;
    assign bus.burst_o = rd_valid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_param_memory.sv
// Directed table-driven bench for param_memory: latency, beats, page hits, wrap, abort, reset.
module tb_param_memory;
    import param_memory_pkg::*;

    localparam int BURSTS   = 4;
    localparam int MISS_LAT = 50;
`ifdef PARAM_MEMORY_PAGE_HIT_EN
    localparam int HIT_LAT  = 25;
`else
    localparam int HIT_LAT  = 50;
`endif

    typedef struct {
        bit          is_rd;
        bit          both;
        logic [31:0] addr;
        line_t       wdata;
        int          lat;
        line_t       exp;
        int          abort_beat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    param_memory_if ifc ();

    param_memory dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic line_t mk_line(input logic [63:0] b0, input logic [63:0] b1,
                                      input logic [63:0] b2, input logic [63:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic vec_t mkv(input bit rd, input bit both, input logic [31:0] a,
                                 input line_t w, input int lat, input line_t e, input int ab);
        vec_t v;
        v.is_rd = rd; v.both = both; v.addr = a; v.wdata = w;
        v.lat = lat; v.exp = e; v.abort_beat = ab;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        bit got;
        bit aborted;
        @(negedge clk);
        ifc.address = v.addr;
        ifc.read    = v.is_rd | v.both;
        ifc.write   = !v.is_rd | v.both;
        ifc.burst_i = '0;
        @(posedge clk);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc <= 300) begin
            @(negedge clk);
            if (ifc.resp) got = 1'b1;
            else cyc++;
        end
        chk($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.lat));
        $display("txn v%0d %s addr=%08h latency=%0d", idx,
                 v.both ? "both" : (v.is_rd ? "read" : "write"), v.addr, cyc);
        if (!got) begin
            ifc.read  = 1'b0;
            ifc.write = 1'b0;
            return;
        end
        aborted = 1'b0;
        for (int k = 0; k < BURSTS; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("v%0d resp beat%0d", idx, k), 64'(ifc.resp), 64'd1);
            chk($sformatf("v%0d data beat%0d", idx, k), ifc.burst_o, v.exp[k]);
            ifc.burst_i = v.wdata[k];
            if (k == v.abort_beat) begin
                ifc.read  = 1'b0;
                ifc.write = 1'b0;
                aborted   = 1'b1;
                break;
            end
        end
        @(negedge clk);
        chk($sformatf("v%0d resp after", idx), 64'(ifc.resp), 64'd0);
        chk($sformatf("v%0d data after", idx), ifc.burst_o, 64'd0);
        if (!aborted) begin
            ifc.read  = 1'b0;
            ifc.write = 1'b0;
        end
    endtask

    initial begin
        vec_t  vecs[11];
        vec_t  tail[2];
        line_t zl, d1, dead, aw, part, bad;
        bit    seen;

        zl   = '0;
        d1   = mk_line(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                       64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        dead = mk_line(64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
                       64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003);
        aw   = mk_line(64'hAAAA_0000_0000_0000, 64'hAAAA_0000_0000_0001,
                       64'hAAAA_0000_0000_0002, 64'hAAAA_0000_0000_0003);
        part = mk_line(64'hAAAA_0000_0000_0000, 64'hAAAA_0000_0000_0001,
                       64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444);
        bad  = mk_line(64'hBAD0_BAD0_BAD0_BAD0, 64'hBAD1_BAD1_BAD1_BAD1,
                       64'hBAD2_BAD2_BAD2_BAD2, 64'hBAD3_BAD3_BAD3_BAD3);

        vecs[0]  = mkv(1'b1, 1'b0, 32'h0000_0040, zl,   MISS_LAT, zl,   -1); // cold read
        vecs[1]  = mkv(1'b0, 1'b0, 32'h0000_0040, d1,   HIT_LAT,  zl,   -1); // write, same page
        vecs[2]  = mkv(1'b1, 1'b0, 32'h0000_0060, zl,   HIT_LAT,  zl,   -1); // neighbour line
        vecs[3]  = mkv(1'b1, 1'b0, 32'h0000_0040, zl,   HIT_LAT,  d1,   -1); // read back
        vecs[4]  = mkv(1'b1, 1'b0, 32'h0000_0140, zl,   MISS_LAT, zl,   -1); // other page
        vecs[5]  = mkv(1'b0, 1'b0, 32'h0000_4000, dead, MISS_LAT, zl,   -1); // line 512
        vecs[6]  = mkv(1'b1, 1'b0, 32'h0000_0000, zl,   MISS_LAT, dead, -1); // wraps to line 0
        vecs[7]  = mkv(1'b0, 1'b0, 32'h0000_0040, aw,   HIT_LAT,  zl,    2); // drop in beat 2
        vecs[8]  = mkv(1'b1, 1'b0, 32'h0000_0040, zl,   HIT_LAT,  part, -1);
        vecs[9]  = mkv(1'b1, 1'b1, 32'h0000_0040, bad,  HIT_LAT,  part, -1); // read wins
        vecs[10] = mkv(1'b1, 1'b0, 32'h0000_0040, zl,   HIT_LAT,  part, -1); // unchanged
        tail[0]  = mkv(1'b1, 1'b0, 32'h0000_0140, zl,   MISS_LAT, zl,   -1); // page invalid after reset
        tail[1]  = mkv(1'b1, 1'b0, 32'h0000_0040, zl,   MISS_LAT, part, -1);

        ifc.read    = 1'b0;
        ifc.write   = 1'b0;
        ifc.address = '0;
        ifc.burst_i = '0;

        repeat (3) @(negedge clk);
        chk("reset resp", 64'(ifc.resp), 64'd0);
        chk("reset burst_o", ifc.burst_o, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post-reset resp", 64'(ifc.resp), 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset while waiting: the request must vanish without a single beat.
        @(negedge clk);
        ifc.address = 32'h0000_0140;
        ifc.read    = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midop reset resp", 64'(ifc.resp), 64'd0);
        chk("midop reset burst_o", ifc.burst_o, 64'd0);
        ifc.read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (ifc.resp) seen = 1'b1;
        end
        chk("midop reset no beats", 64'(seen), 64'd0);
        $display("txn reset-during-wait beats_seen=%0d", seen);

        for (int i = 0; i < 2; i++) begin
            run_vec(tail[i], 11 + i);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
